// File: rtl/core_pkg.sv
// Shared types and constants for the core pipeline control blocks.
package core_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mc_state_e;

endpackage

// File: rtl/forward_unit.sv
// Two-operand EX-stage forwarding compare; the memory stage has priority over writeback.
module forward_unit
   import core_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W
)(
   input  logic [ADDR_W-1:0] rs1,
   input  logic [ADDR_W-1:0] rs2,
   input  logic [ADDR_W-1:0] rd_m,
   input  logic [ADDR_W-1:0] rd_w,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   output fwd_sel_e          fwd_a,
   output fwd_sel_e          fwd_b
);

   logic mem_ok;
   logic wb_ok;

   // Register x0 is hardwired to zero, so a write to it never produces a forwardable value.
   always_comb begin
      mem_ok = reg_write_m && (rd_m != '0);
      wb_ok  = reg_write_w && (rd_w != '0);
   end

   // Pick the youngest producer for each operand, falling back to the register file.
   always_comb begin
      fwd_a = FWD_RF;
      fwd_b = FWD_RF;
      if (mem_ok && (rd_m == rs1)) begin
         fwd_a = FWD_MEM;
      end else if (wb_ok && (rd_w == rs1)) begin
         fwd_a = FWD_WB;
      end
      if (mem_ok && (rd_m == rs2)) begin
         fwd_b = FWD_MEM;
      end else if (wb_ok && (rd_w == rs2)) begin
         fwd_b = FWD_WB;
      end
   end

endmodule

// File: rtl/hazard_sched_unit.sv
// Pipeline hazard controller: forwarding selects, load-use stall, branch flush,
// and start/done sequencing of the multi-cycle execute unit.
module hazard_sched_unit #(
   parameter int REG_ADDR_W = core_pkg::REG_ADDR_W,
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] Rs1D,
   input  logic [REG_ADDR_W-1:0] Rs2D,
   input  logic [REG_ADDR_W-1:0] Rs1E,
   input  logic [REG_ADDR_W-1:0] Rs2E,
   input  logic [REG_ADDR_W-1:0] RdE,
   input  logic [REG_ADDR_W-1:0] RdM,
   input  logic [REG_ADDR_W-1:0] RdW,
   input  logic                  RegWriteM,
   input  logic                  RegWriteW,
   input  logic                  ResultSrcE0,
   input  logic                  PCSrcE,
   input  logic                  MultiCycleE,
   input  logic                  McDone,
   output logic [1:0]            ForwardAE,
   output logic [1:0]            ForwardBE,
   output logic                  StallF,
   output logic                  StallD,
   output logic                  StallE,
   output logic                  FlushD,
   output logic                  FlushE,
   output logic                  FlushM,
   output logic                  McStart,
   output logic                  McBusy,
   output logic                  McTimeout
);

   import core_pkg::*;

   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MC_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

   mc_state_e        state;
   logic [CNT_W-1:0] busy_cnt;
   logic             timeout_flag;
   logic             lw_stall;
   logic             mc_hold;
   fwd_sel_e         fwd_a;
   fwd_sel_e         fwd_b;

   forward_unit #(
      .ADDR_W(REG_ADDR_W)
   ) u_forward (
      .rs1        (Rs1E),
      .rs2        (Rs2E),
      .rd_m       (RdM),
      .rd_w       (RdW),
      .reg_write_m(RegWriteM),
      .reg_write_w(RegWriteW),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b)
   );

   // Forwarding stays live in every cycle, including stalls and reset.
   always_comb begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
   end

   // Hazard terms: a load in EX feeding decode, and the multi-cycle unit owning the front end.
   always_comb begin
      lw_stall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));
      mc_hold  = ((state == IDLE) && MultiCycleE) || (state == BUSY);
   end

   // Stall/flush equations; a pending multi-cycle op masks branch and load-use flushes.
   always_comb begin
      StallF  = 1'b0;
      StallD  = 1'b0;
      StallE  = 1'b0;
      FlushD  = 1'b0;
      FlushE  = 1'b0;
      FlushM  = 1'b0;
      McStart = 1'b0;
      McBusy  = 1'b0;
      if (!rst) begin
         StallF  = lw_stall || mc_hold;
         StallD  = lw_stall || mc_hold;
         StallE  = (state == BUSY);
         FlushD  = PCSrcE && !mc_hold;
         FlushE  = (lw_stall || PCSrcE) && !mc_hold;
         FlushM  = (state == BUSY);
         McStart = (state == IDLE) && MultiCycleE;
         McBusy  = (state == BUSY);
      end
   end

   // Sticky error flag is kept as a register so it survives the retire.
   always_comb begin
      McTimeout = timeout_flag;
   end

   // Multi-cycle sequencer: IDLE launches, BUSY counts until done or timeout, DONE retires for one cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         busy_cnt     <= '0;
         timeout_flag <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (MultiCycleE) begin
                  state    <= BUSY;
                  busy_cnt <= '0;
               end
            end
            BUSY: begin
               if (busy_cnt != '1) begin
                  busy_cnt <= busy_cnt + CNT_ONE;
               end
               if (McDone) begin
                  state <= DONE;
               end else if (busy_cnt == TIMEOUT_LAST) begin
                  timeout_flag <= 1'b1;
                  state        <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
